// File: rtl/inst_fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch front-end.
package inst_fetch_unit_pkg;

  localparam int unsigned IFU_DEPTH    = 4;
  localparam logic [31:0] IFU_RESET_PC = 32'h0;
  localparam int unsigned INST_W       = 32;

  // One buffered fetch: the instruction word and the PC it was fetched from.
  typedef struct packed {
    logic [31:0]       pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_fetch_queue.sv
// Small synchronous FIFO of fetch entries; flush wins over push.
module fetch_queue
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = IFU_DEPTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = AW + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop & ~empty;
  assign do_push = push & ~flush;

  // Pointer and occupancy tracking; flush empties the queue outright.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Entry storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues word fetches,
// buffers responses with their PCs and streams them to the core.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH    = IFU_DEPTH,
  parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        idle
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [31:0]   fetch_pc;
  logic [31:0]   resp_pc;
  logic [31:0]   redirect_target;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] q_count;
  logic [CW:0]   in_use;
  logic          req_fire;
  logic          q_push;
  logic          q_pop;
  logic          q_full;
  logic          q_empty;
  fetch_entry_t  q_push_data;
  fetch_entry_t  q_head;

  // Queued plus in-flight fetches are capped at DEPTH so every response has a slot.
  assign in_use          = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_valid  = reset & ~halt & ~redirect_valid & (in_use < (CW+1)'(DEPTH));
  assign imem_req_addr   = fetch_pc;
  assign req_fire        = imem_req_valid & imem_req_ready;

  assign redirect_target  = word_align(redirect_pc);
  assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_resp_valid);

  // Stale responses are swallowed while drop_cnt is nonzero; a redirect flushes any push.
  assign q_push      = imem_resp_valid & (drop_cnt == '0);
  assign q_push_data = '{pc: resp_pc, inst: imem_resp_data};
  assign q_pop       = inst_valid & inst_ready;

  fetch_queue #(
    .DEPTH(DEPTH)
  ) u_queue (
    .clk      (clk),
    .reset    (reset),
    .push     (q_push),
    .push_data(q_push_data),
    .pop      (q_pop),
    .flush    (redirect_valid),
    .head     (q_head),
    .count    (q_count),
    .full     (q_full),
    .empty    (q_empty)
  );

  // Outstanding/drop accounting; a redirect marks everything still in flight as stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid)
        drop_cnt <= outstanding_next;
      else if (imem_resp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - CW'(1);
    end
  end

  // Fetch PC advances per accepted request, response PC per kept response.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
      resp_pc  <= redirect_target;
    end else begin
      if (req_fire) fetch_pc <= fetch_pc + 32'd4;
      if (q_push)   resp_pc  <= resp_pc + 32'd4;
    end
  end

  assign inst_valid = ~q_empty;
  assign inst       = q_head.inst;
  assign inst_pc    = q_head.pc;
  assign idle       = q_empty & (outstanding == '0);

  // The issue cap must make an overflowing push impossible.
  push_not_full_a: assert property (@(posedge clk) disable iff (!reset)
    !(q_push && !redirect_valid && q_full));

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Randomised bench for inst_fetch_unit with a queue-based reference model.
module tb_inst_fetch_unit;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        idle;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .idle           (idle)
  );

  typedef struct { logic [31:0] data; longint due; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;

  int checks   = 0;
  int failures = 0;
  longint cyc  = 0;
  longint last_due = 0;

  // environment knobs
  int unsigned lat_min = 1, lat_max = 1, p_mready = 100, p_iready = 100;
  bit          halt_ctl = 0, redir_req = 0;
  logic [31:0] redir_tgt = '0;

  pend_t       pend[$];
  ent_t        mq[$];
  int          m_out, m_drop;
  logic [31:0] m_fpc, m_rpc;
  logic [31:0] acc_log[$];
  logic [31:0] del_log[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE ^ a[31:16], a[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_q(input string name, input logic [31:0] q[$], input int idx,
                       input logic [31:0] exp);
    if (idx >= q.size()) begin
      checks++;
      failures++;
      $display("FAIL %s actual=<missing> required=%h cycle=%0d", name, exp, cyc);
    end else begin
      chk(name, q[idx], exp);
    end
  endtask

  task automatic drive();
    if (!reset) begin
      imem_req_ready  = 1'b0;
      inst_ready      = 1'b0;
      halt            = 1'b0;
      redirect_valid  = 1'b0;
      redirect_pc     = '0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
      redir_req       = 1'b0;
    end else begin
      imem_req_ready = ($urandom_range(99) < p_mready);
      inst_ready     = ($urandom_range(99) < p_iready);
      halt           = halt_ctl;
      redirect_valid = redir_req;
      redirect_pc    = redir_tgt;
      redir_req      = 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = pend[0].data;
        void'(pend.pop_front());
      end else begin
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
      end
    end
  endtask

  // One clock: drive inputs, compare at negedge, advance model, resync after posedge.
  task automatic tick();
    bit     exp_rv;
    bit     fire;
    longint due;
    drive();
    @(negedge clk);
    if (!reset) begin
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_inst_valid", inst_valid, 0);
      chk("rst_idle", idle, 1);
    end else begin
      exp_rv = !halt && !redirect_valid && (mq.size() + m_out < DEPTH);
      chk("req_valid", imem_req_valid, exp_rv);
      if (exp_rv) chk("req_addr", imem_req_addr, m_fpc);
      chk("inst_valid", inst_valid, mq.size() != 0);
      if (mq.size() != 0) begin
        chk("inst_pc", inst_pc, mq[0].pc);
        chk("inst", inst, mq[0].inst);
      end
      chk("idle", idle, (mq.size() == 0) && (m_out == 0));
      // memory environment reacts to what the DUT actually handshakes
      if (imem_req_valid && imem_req_ready) begin
        due = cyc + longint'($urandom_range(lat_max, lat_min));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend.push_back('{mem_word(imem_req_addr), due});
        acc_log.push_back(imem_req_addr);
      end
      if (inst_valid && inst_ready) del_log.push_back(inst_pc);
      // reference model update
      fire = exp_rv && imem_req_ready;
      if (mq.size() != 0 && inst_ready) void'(mq.pop_front());
      if (imem_resp_valid) begin
        m_out--;
        if (m_drop > 0) m_drop--;
        else if (!redirect_valid) begin
          mq.push_back('{m_rpc, mem_word(m_rpc)});
          m_rpc += 32'd4;
        end
      end
      if (fire) begin
        m_out++;
        m_fpc += 32'd4;
      end
      if (redirect_valid) begin
        mq.delete();
        m_fpc  = {redirect_pc[31:2], 2'b00};
        m_rpc  = m_fpc;
        m_drop = m_out;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Release reset (caller holds it low); model and memory start empty.
  task automatic start_run();
    mq.delete();
    pend.delete();
    acc_log.delete();
    del_log.delete();
    m_out     = 0;
    m_drop    = 0;
    m_fpc     = RESET_PC;
    m_rpc     = RESET_PC;
    last_due  = cyc;
    redir_req = 1'b0;
    halt_ctl  = 1'b0;
    reset     = 1'b1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ticks(2);
    start_run();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    drive();
    #1;
    chk("reset_req_valid", imem_req_valid, 0);
    chk("reset_inst_valid", inst_valid, 0);
    chk("reset_idle", idle, 1);
    @(posedge clk);
    cyc++;
    #1;

    // straight-line fetch, then redirect coincident with response and pop
    lat_min = 1; lat_max = 1; p_mready = 100; p_iready = 100;
    start_run();
    ticks(2);
    chk("sl_valid0", inst_valid, 1);
    chk("sl_pc0", inst_pc, 32'h0);
    chk("sl_inst0", inst, 32'hC0DE_0000);
    tick();
    chk("sl_pc1", inst_pc, 32'h4);
    tick();
    chk("sl_pc2", inst_pc, 32'h8);
    tick();
    chk("sl_pc3", inst_pc, 32'hC);
    chk("sl_inst3", inst, 32'hC0DE_000C);
    tick();
    redir_req = 1'b1; redir_tgt = 32'h0000_0203;
    tick();
    chk("coinc_flushed", inst_valid, 0);
    ticks(4);
    chk_q("coinc_popped", del_log, 4, 32'h10);
    chk_q("coinc_target", del_log, 5, 32'h200);

    // backpressure
    do_reset();
    p_iready = 0;
    ticks(10);
    chk("bp_req_count", acc_log.size(), 4);
    chk_q("bp_last_addr", acc_log, 3, 32'hC);
    chk("bp_req_stalled", imem_req_valid, 0);
    p_iready = 100;
    ticks(10);
    chk_q("bp_pop3", del_log, 3, 32'hC);
    chk_q("bp_resume_addr", acc_log, 4, 32'h10);

    // redirect with two fetches in flight
    do_reset();
    lat_min = 3; lat_max = 3;
    ticks(2);
    redir_req = 1'b1; redir_tgt = 32'h0000_0103;
    ticks(10);
    chk_q("rd_next_addr", acc_log, 2, 32'h100);
    chk_q("rd_first_pc", del_log, 0, 32'h100);

    // halt with two in flight
    do_reset();
    ticks(2);
    halt_ctl = 1'b1;
    ticks(6);
    chk("halt_req_count", acc_log.size(), 2);
    chk("halt_idle", idle, 1);
    chk("halt_delivered", del_log.size(), 2);
    halt_ctl = 1'b0;
    ticks(2);
    chk_q("halt_resume_addr", acc_log, 2, 32'h8);

    // randomised traffic with an asynchronous reset midway
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      lat_min  = 1;
      lat_max  = $urandom_range(5, 1);
      p_mready = (blk % 3 == 0) ? 100 : ((blk % 3 == 1) ? 70 : 40);
      p_iready = (blk % 4 == 0) ? 100 : ((blk % 4 == 1) ? 60 : ((blk % 4 == 2) ? 20 : 90));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(99) < 5) halt_ctl = ~halt_ctl;
        if ($urandom_range(99) < 4) begin
          redir_req = 1'b1;
          redir_tgt = $urandom;
        end
        tick();
      end
      if (blk == 6) begin
        #2;
        reset = 1'b0;
        #1;
        chk("async_inst_valid", inst_valid, 0);
        chk("async_req_valid", imem_req_valid, 0);
        @(posedge clk);
        cyc++;
        #1;
        tick();
        start_run();
        tick();
        chk_q("async_first_addr", acc_log, 0, RESET_PC);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
